fifo_dual_bank_ctrl: RTL
========================

Name: fifo_dual_bank_ctrl

Overview:
- 2-wide FIFO with up to 2 enqueues and 2 dequeues per cycle, in-order.
- Storage is split into 2 single-write-port banks interleaved by pointer LSB.
- The block owns the head/tail/count state and computes the per-cycle bank shift values.
- Write lanes are depermuted into banks; bank read data is permuted back into lanes.
- Serves as the front-end queue between fetch/decode and rename.

Parameters:
- WIDTH, 32, entry data width in bits.
- DEPTH, 8, total entries; power of 2, >= 4; each bank holds DEPTH/2 rows.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_flush  input  1  synchronous flush; empties the queue.
- i_enq_valid  input  2  per-lane enqueue request; lane 0 is oldest.
- i_enq_data  input  2 x WIDTH (unpacked [0:1])  enqueue data per lane.
- o_enq_ready  output  2  per-lane space available.
- o_deq_valid  output  2  per-lane entry available; lane 0 is oldest.
- o_deq_data  output  2 x WIDTH (unpacked [0:1])  head entries.
- i_deq_ready  input  2  per-lane consumer accept.
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- State: head and tail, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count, $clog2(DEPTH)+1 bits.
- Address mapping: bank = ptr[0]; row = ptr >> 1.
- Reset (async assert, independent of the clock): head=0, tail=0, count=0.
  - Reset outputs: o_deq_valid=00, o_enq_ready=11, o_count=0.
  - Storage is not reset.
- o_enq_ready: 11 if free>=2; 01 if free==1; 00 if full. free = DEPTH - count. Computed from registered count only; no same-cycle dequeue credit.
- o_deq_valid: 11 if count>=2; 01 if count==1; 00 if empty.
- Lanes must be contiguous:
  - Lane 1 enqueues only if lane 0 also enqueues.
  - enq_n = 2 if (valid & ready) == 11; 1 if lane 0 fires; 0 otherwise. Pattern 10 accepts nothing.
  - deq_n follows the same rule on (o_deq_valid & i_deq_ready).
- Enqueue writes:
  - Lane k writes address tail+k.
  - Lane data is depermuted to banks with shift = tail[0].
  - Bank b row = (tail>>1) if b==tail[0], else ((tail+1)>>1) mod DEPTH/2.
  - Writes take effect at the clock edge.
- Dequeue reads:
  - o_deq_data[k] = entry at head+k.
  - Bank outputs are permuted to lanes with shift = head[0], using the same row rule on head.
  - Combinational from registered head and storage.
  - o_deq_data is don't-care for lanes whose valid is low.
- Next state: tail += enq_n; head += deq_n; count += enq_n - deq_n. All updates in the same cycle.
- No bypass: an entry enqueued in cycle N is first visible on o_deq_* in cycle N+1.
- Simultaneous enq and deq when full: enq_ready=00, so deq_n entries leave and nothing enters. enq_ready reopens next cycle.
- Simultaneous enq and deq when empty: nothing dequeues; enqueued entries appear next cycle.
- Wrap-around: pointers wrap naturally. A 2-wide enqueue at tail=DEPTH-1 writes bank 1 row DEPTH/2-1 and bank 0 row 0.
- i_flush:
  - Next edge: head=tail=0, count=0.
  - Same-cycle enqueues and dequeues are discarded; flush has priority.
  - Outputs during the flush cycle still reflect pre-flush state.
- Invariants (bench asserts): count <= DEPTH; count == (tail - head) mod DEPTH, except count==DEPTH when tail==head.

Test Plan:
- Reset, then enq 2 (A,B) at tail=0 -> next cycle o_deq_valid=11, o_deq_data={A,B}, o_count=2, tail=2.
- Enq 1 (A); then enq 2 (B,C) with tail=1 (odd shift) -> B in bank1 row0, C in bank0 row1. Deq 1 per cycle yields A, B, C in order.
- Fill DEPTH=8 with 2-wide enqueues -> o_enq_ready 11,11,11,11 then 00. With count=7, o_enq_ready=01 and enq_valid=11 accepts lane 0 only.
- Full queue, enq_valid=11 and deq_ready=11 -> 2 entries leave, 0 enter; o_count=6 next cycle, then o_enq_ready=11.
- Stream 20 entries with random 0/1/2 enq/deq mixes across pointer wrap -> dequeue order matches a scoreboard exactly. Patterns enq_valid=10 and deq_ready=10 move nothing.
- Mid-stream: i_flush with count=5 -> next cycle o_count=0, o_deq_valid=00. Asserting i_rst_n=0 mid-cycle -> outputs reset immediately, before the next clock edge.

Source files
------------

// File: rtl/fifo_dual_bank_ctrl.sv
// Two-wide in-order FIFO over two single-write-port banks interleaved by pointer LSB.
// Owns head/tail/count and does the lane<->bank permutation on both ports.
module fifo_dual_bank_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [1:0]               i_enq_valid,
  input  logic [WIDTH-1:0]         i_enq_data [0:1],
  output logic [1:0]               o_enq_ready,
  output logic [1:0]               o_deq_valid,
  output logic [WIDTH-1:0]         o_deq_data [0:1],
  input  logic [1:0]               i_deq_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned RW   = AW - 1;
  localparam int unsigned ROWS = DEPTH / 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    head, tail, head_p1, tail_p1;
  logic [CW-1:0]    count, free;
  logic [1:0]       enq_fire, deq_fire, enq_n, deq_n, lane_wr, wr_en;
  logic [RW-1:0]    wr_row0, wr_row1, rd_row0, rd_row1;
  logic [WIDTH-1:0] wr_data0, wr_data1, rd_q0, rd_q1;
  logic [WIDTH-1:0] bank0 [ROWS];
  logic [WIDTH-1:0] bank1 [ROWS];

  always_comb begin
    free    = DEPTH_C - count;
    head_p1 = head + AW'(1);
    tail_p1 = tail + AW'(1);

    if (free >= CW'(2))      o_enq_ready = 2'b11;
    else if (free == CW'(1)) o_enq_ready = 2'b01;
    else                     o_enq_ready = 2'b00;

    if (count >= CW'(2))      o_deq_valid = 2'b11;
    else if (count == CW'(1)) o_deq_valid = 2'b01;
    else                      o_deq_valid = 2'b00;

    // Lane 1 only counts when lane 0 also fires, so pattern 10 moves nothing.
    enq_fire = i_enq_valid & o_enq_ready;
    deq_fire = o_deq_valid & i_deq_ready;
    enq_n    = (enq_fire == 2'b11) ? 2'd2 : (enq_fire[0] ? 2'd1 : 2'd0);
    deq_n    = (deq_fire == 2'b11) ? 2'd2 : (deq_fire[0] ? 2'd1 : 2'd0);
  end

  // Depermute lanes into banks: lane k lands in bank (tail[0] ^ k).
  always_comb begin
    lane_wr  = {enq_n == 2'd2, enq_n != 2'd0};
    wr_row0  = tail[0] ? tail_p1[AW-1:1] : tail[AW-1:1];
    wr_row1  = tail[0] ? tail[AW-1:1]    : tail_p1[AW-1:1];
    wr_data0 = tail[0] ? i_enq_data[1]   : i_enq_data[0];
    wr_data1 = tail[0] ? i_enq_data[0]   : i_enq_data[1];
    wr_en[0] = !i_flush && (tail[0] ? lane_wr[1] : lane_wr[0]);
    wr_en[1] = !i_flush && (tail[0] ? lane_wr[0] : lane_wr[1]);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en[0]) bank0[wr_row0] <= wr_data0;
    if (wr_en[1]) bank1[wr_row1] <= wr_data1;
  end

  always_comb begin
    rd_row0       = head[0] ? head_p1[AW-1:1] : head[AW-1:1];
    rd_row1       = head[0] ? head[AW-1:1]    : head_p1[AW-1:1];
    rd_q0         = bank0[rd_row0];
    rd_q1         = bank1[rd_row1];
    o_deq_data[0] = head[0] ? rd_q1 : rd_q0;
    o_deq_data[1] = head[0] ? rd_q0 : rd_q1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(enq_n);
      head  <= head + AW'(deq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  assign o_count = count;

endmodule
